// File: rtl/traffic_supervisor.sv
// Supervisor in front of traffic_control: debounces pedestrian buttons into
// held request levels, watches the lamp pair for conflicts and stuck aspects,
// and sequences the ERR line through fault hold, optional latch and recovery.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// RUN      | normal operation, conflict/stuck/external faults evaluated
// FAULT    | ERR high, minimum hold timer running
// HOLD     | ERR high, latched until flt_clr with ext_err low
// RECOVER  | ERR low, lamp checks masked while controller lamps settle
module traffic_supervisor #(
    parameter int unsigned DEB_CYC   = 4,
    parameter int unsigned WDOG_MAX  = 16,
    parameter int unsigned ERR_HOLD  = 12,
    parameter bit          LATCH_FLT = 1'b0
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       btn_a,
    input  logic       btn_b,
    input  logic       ext_err,
    input  logic       flt_clr,
    input  logic [2:0] L_A,
    input  logic [2:0] L_B,
    input  logic       RA,
    input  logic       RB,
    output logic       PA,
    output logic       PB,
    output logic       ERR,
    output logic [1:0] flt_code,
    output logic [7:0] flt_cnt
);

    localparam int DW = $clog2(DEB_CYC + 1);
    localparam int WW = $clog2(WDOG_MAX + 1);
    localparam int TW = $clog2(ERR_HOLD + 1);
    localparam logic [DW-1:0] DEB_TOP = DW'(DEB_CYC);
    localparam logic [DW-1:0] DEB_PRE = DW'(DEB_CYC - 1);
    localparam logic [WW-1:0] WD_TOP  = WW'(WDOG_MAX);
    localparam logic [TW-1:0] HOLD_LD = TW'(ERR_HOLD - 1);
    // RECOVER lasts two cycles: load 1, leave when the timer reads 0
    localparam logic [TW-1:0] REC_LD  = TW'(1);

    typedef enum logic [1:0] {S_RUN, S_FAULT, S_HOLD, S_RECOVER} state_t;

    state_t               state_q, state_d;
    logic [1:0]           sync1_q, sync2_q;
    logic [1:0][DW-1:0]   deb_q, deb_d;
    logic [1:0]           accept;
    logic [1:0]           walk_q;
    logic [1:0]           walk_rise;
    logic [1:0]           pend_q, pend_d;
    logic [5:0]           lamp_q;
    logic [5:0]           pair;
    logic [WW-1:0]        wd_q, wd_d;
    logic [TW-1:0]        tmr_q, tmr_d;
    logic [1:0]           code_q, code_d;
    logic [7:0]           cnt_q, cnt_d;
    logic                 err_q, err_d;
    logic                 conflict, stuck, in_err;
    logic [1:0]           cause;

    function automatic logic is_go(input logic [2:0] l);
        return (l == 3'b110) || (l == 3'b101) || (l == 3'b100);
    endfunction

    // Two-flop synchronisers for the asynchronous buttons
    always_ff @(posedge CLK) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {btn_b, btn_a};
            sync2_q <= sync1_q;
        end
    end

    // Debounce counters; accept fires only on the step that reaches DEB_CYC
    always_comb begin
        deb_d  = deb_q;
        accept = '0;
        for (int i = 0; i < 2; i++) begin
            if (!sync2_q[i]) begin
                deb_d[i] = '0;
            end else if (deb_q[i] != DEB_TOP) begin
                deb_d[i]  = deb_q[i] + DW'(1);
                accept[i] = (deb_q[i] == DEB_PRE);
            end
        end
    end

    assign pair      = {L_A, L_B};
    assign walk_rise = {RB, RA} & ~walk_q;
    assign in_err    = (state_q == S_FAULT) || (state_q == S_HOLD);
    assign conflict  = is_go(L_A) && is_go(L_B);

    // Watchdog on the lamp pair; flash pairs are legitimately static
    always_comb begin
        wd_d = wd_q;
        if ((pair != lamp_q) || (pair == 6'b000000) || (pair == 6'b111111)) begin
            wd_d = '0;
        end else if (wd_q != WD_TOP) begin
            wd_d = wd_q + WW'(1);
        end
    end
    assign stuck = (wd_d == WD_TOP);

    // Pending requests: walk edge clears and beats a coincident accept
    always_comb begin
        pend_d = pend_q;
        for (int i = 0; i < 2; i++) begin
            if (in_err || walk_rise[i]) begin
                pend_d[i] = 1'b0;
            end else if (accept[i]) begin
                pend_d[i] = 1'b1;
            end
        end
    end

    // Fault sequencer next-state, timer and fault bookkeeping
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        code_d  = code_q;
        cnt_d   = cnt_q;
        cause   = 2'b00;
        if (ext_err)       cause = 2'b11;
        else if (conflict) cause = 2'b01;
        else if (stuck)    cause = 2'b10;
        case (state_q)
            S_RUN: begin
                if (cause != 2'b00) begin
                    state_d = S_FAULT;
                    tmr_d   = HOLD_LD;
                    code_d  = cause;
                    cnt_d   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                end
            end
            S_FAULT: begin
                if (tmr_q != '0) begin
                    tmr_d = tmr_q - TW'(1);
                end else if (!ext_err) begin
                    state_d = LATCH_FLT ? S_HOLD : S_RECOVER;
                    tmr_d   = REC_LD;
                end
            end
            S_HOLD: begin
                if (flt_clr && !ext_err) begin
                    state_d = S_RECOVER;
                    tmr_d   = REC_LD;
                end
            end
            S_RECOVER: begin
                if (ext_err) begin
                    state_d = S_FAULT;
                    tmr_d   = HOLD_LD;
                    code_d  = 2'b11;
                    cnt_d   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                end else if (tmr_q == '0) begin
                    state_d = S_RUN;
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            default: state_d = S_RUN;
        endcase
        err_d = (state_d == S_FAULT) || (state_d == S_HOLD);
    end

    // All state registers
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q <= S_RUN;
            deb_q   <= '0;
            walk_q  <= '0;
            pend_q  <= '0;
            lamp_q  <= '0;
            wd_q    <= '0;
            tmr_q   <= '0;
            code_q  <= 2'b00;
            cnt_q   <= 8'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            deb_q   <= deb_d;
            walk_q  <= {RB, RA};
            pend_q  <= pend_d;
            lamp_q  <= pair;
            wd_q    <= wd_d;
            tmr_q   <= tmr_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign PA       = pend_q[0];
    assign PB       = pend_q[1];
    assign ERR      = err_q;
    assign flt_code = code_q;
    assign flt_cnt  = cnt_q;

endmodule

// File: tb/tb_traffic_supervisor.sv
// Bench for traffic_supervisor: an auto-recovering and a latching instance share
// one stimulus stream; a behavioural model predicts every output each cycle.
module tb_traffic_supervisor;

    localparam int DEB  = 4;
    localparam int WDOG = 16;
    localparam int HOLD = 12;

    localparam int M_NORMAL  = 0;
    localparam int M_TIMED   = 1;
    localparam int M_LATCHED = 2;
    localparam int M_SETTLE  = 3;

    logic       CLK = 1'b0;
    logic       reset = 1'b1;
    logic       btn_a = 1'b0, btn_b = 1'b0, ext_err = 1'b0, flt_clr = 1'b0;
    logic [2:0] L_A = 3'b000, L_B = 3'b000;
    logic       RA = 1'b0, RB = 1'b0;

    logic       PA0, PB0, ERR0, PA1, PB1, ERR1;
    logic [1:0] code0, code1;
    logic [7:0] cnt0, cnt1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int mode;
        int elapsed;
        int code;
        int cnt;
        bit pa;
        bit pb;
        bit latch;
    } mdl_t;

    mdl_t m0, m1;
    bit   qa[$];
    bit   qb[$];
    bit   prev_ra, prev_rb;
    logic [5:0] last_pair;
    int   same_run;

    traffic_supervisor #(.DEB_CYC(DEB), .WDOG_MAX(WDOG), .ERR_HOLD(HOLD), .LATCH_FLT(1'b0)) dut (
        .CLK(CLK), .reset(reset), .btn_a(btn_a), .btn_b(btn_b), .ext_err(ext_err),
        .flt_clr(flt_clr), .L_A(L_A), .L_B(L_B), .RA(RA), .RB(RB),
        .PA(PA0), .PB(PB0), .ERR(ERR0), .flt_code(code0), .flt_cnt(cnt0));

    traffic_supervisor #(.DEB_CYC(DEB), .WDOG_MAX(WDOG), .ERR_HOLD(HOLD), .LATCH_FLT(1'b1)) dut_l (
        .CLK(CLK), .reset(reset), .btn_a(btn_a), .btn_b(btn_b), .ext_err(ext_err),
        .flt_clr(flt_clr), .L_A(L_A), .L_B(L_B), .RA(RA), .RB(RB),
        .PA(PA1), .PB(PB1), .ERR(ERR1), .flt_code(code1), .flt_cnt(cnt1));

    always #5 CLK = ~CLK;

    function automatic mdl_t fresh(input bit latch);
        mdl_t m;
        m.mode = M_NORMAL; m.elapsed = 0; m.code = 0; m.cnt = 0;
        m.pa = 1'b0; m.pb = 1'b0; m.latch = latch;
        return m;
    endfunction

    // A press is accepted when the level seen through the two synchroniser
    // stages (two samples ago) completes a run of exactly DEB high samples.
    function automatic bit accepted(input bit q[$]);
        int run = 0;
        for (int i = q.size() - 3; i >= 0; i--) begin
            if (!q[i]) break;
            run++;
        end
        return run == DEB;
    endfunction

    function automatic bit go(input logic [2:0] l);
        return (l == 3'd6) || (l == 3'd5) || (l == 3'd4);
    endfunction

    function automatic mdl_t advance(input mdl_t m, input bit acc_a, input bit acc_b,
                                     input bit rise_a, input bit rise_b, input bit conf,
                                     input bit stk, input bit ext, input bit clr);
        mdl_t n = m;
        bit in_err = (m.mode == M_TIMED) || (m.mode == M_LATCHED);
        int cause = ext ? 3 : conf ? 1 : stk ? 2 : 0;
        n.pa = in_err ? 1'b0 : rise_a ? 1'b0 : acc_a ? 1'b1 : m.pa;
        n.pb = in_err ? 1'b0 : rise_b ? 1'b0 : acc_b ? 1'b1 : m.pb;
        if (m.mode == M_NORMAL) begin
            if (cause != 0) begin
                n.mode = M_TIMED; n.elapsed = 0; n.code = cause;
                n.cnt = (m.cnt < 255) ? m.cnt + 1 : 255;
            end
        end else if (m.mode == M_TIMED) begin
            if (m.elapsed < HOLD - 1) n.elapsed = m.elapsed + 1;
            else if (!ext) begin
                n.mode = m.latch ? M_LATCHED : M_SETTLE;
                n.elapsed = 0;
            end
        end else if (m.mode == M_LATCHED) begin
            if (clr && !ext) begin n.mode = M_SETTLE; n.elapsed = 0; end
        end else begin
            if (ext) begin
                n.mode = M_TIMED; n.elapsed = 0; n.code = 3;
                n.cnt = (m.cnt < 255) ? m.cnt + 1 : 255;
            end else if (m.elapsed >= 1) n.mode = M_NORMAL;
            else n.elapsed = m.elapsed + 1;
        end
        return n;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        bit acc_a, acc_b, rise_a, rise_b, conf, stk;
        logic [5:0] pair;
        @(posedge CLK);
        if (reset) begin
            qa.delete(); qb.delete();
            prev_ra = 1'b0; prev_rb = 1'b0;
            last_pair = 6'd0; same_run = 1;
            m0 = fresh(1'b0); m1 = fresh(1'b1);
        end else begin
            qa.push_back(btn_a); qb.push_back(btn_b);
            if (qa.size() > 16) void'(qa.pop_front());
            if (qb.size() > 16) void'(qb.pop_front());
            acc_a = accepted(qa);
            acc_b = accepted(qb);
            rise_a = RA && !prev_ra; prev_ra = RA;
            rise_b = RB && !prev_rb; prev_rb = RB;
            pair = {L_A, L_B};
            if (pair == last_pair) begin
                if (same_run < 1000) same_run++;
            end else same_run = 1;
            last_pair = pair;
            stk = (pair != 6'o00) && (pair != 6'o77) && (same_run > WDOG);
            conf = go(L_A) && go(L_B);
            m0 = advance(m0, acc_a, acc_b, rise_a, rise_b, conf, stk, ext_err, flt_clr);
            m1 = advance(m1, acc_a, acc_b, rise_a, rise_b, conf, stk, ext_err, flt_clr);
        end
        #1;
        chk("PA_auto",    {7'd0, PA0},  {7'd0, m0.pa});
        chk("PB_auto",    {7'd0, PB0},  {7'd0, m0.pb});
        chk("ERR_auto",   {7'd0, ERR0}, {7'd0, (m0.mode == M_TIMED) || (m0.mode == M_LATCHED)});
        chk("code_auto",  {6'd0, code0}, 8'(m0.code));
        chk("cnt_auto",   cnt0, 8'(m0.cnt));
        chk("PA_latch",   {7'd0, PA1},  {7'd0, m1.pa});
        chk("PB_latch",   {7'd0, PB1},  {7'd0, m1.pb});
        chk("ERR_latch",  {7'd0, ERR1}, {7'd0, (m1.mode == M_TIMED) || (m1.mode == M_LATCHED)});
        chk("code_latch", {6'd0, code1}, 8'(m1.code));
        chk("cnt_latch",  cnt1, 8'(m1.cnt));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int lamp_hold = 0, hold_a = 0, hold_b = 0;
        int r;
        m0 = fresh(1'b0); m1 = fresh(1'b1);
        // reset state
        reset = 1'b1; run(3);
        reset = 1'b0; run(2);
        // button A press, then walk acknowledge
        btn_a = 1'b1; run(10);
        btn_a = 1'b0; run(3);
        RA = 1'b1; run(1);
        RA = 1'b0; run(3);
        // button B bounce, then steady press and acknowledge
        btn_b = 1'b1; run(1); btn_b = 1'b0; run(1);
        btn_b = 1'b1; run(2); btn_b = 1'b0; run(1);
        btn_b = 1'b1; run(8); btn_b = 1'b0; run(3);
        RB = 1'b1; run(2); RB = 1'b0; run(2);
        // conflicting greens
        L_A = 3'b110; L_B = 3'b101; run(1);
        L_A = 3'b000; L_B = 3'b000; run(16);
        // stuck lamp pair, then long flash-yellow period
        L_A = 3'b110; L_B = 3'b011; run(20);
        L_A = 3'b000; L_B = 3'b000; run(100);
        // external fault pulse: latching instance waits for flt_clr
        ext_err = 1'b1; run(1);
        ext_err = 1'b0; run(20);
        flt_clr = 1'b1; run(1);
        flt_clr = 1'b0; run(5);
        // reset in the middle of a fault
        ext_err = 1'b1; run(1);
        ext_err = 1'b0; run(4);
        reset = 1'b1; run(1);
        reset = 1'b0; run(3);
        // simultaneous conflict and external fault
        L_A = 3'b110; L_B = 3'b100; ext_err = 1'b1; run(1);
        L_A = 3'b000; L_B = 3'b000; ext_err = 1'b0; run(20);
        flt_clr = 1'b1; run(1);
        flt_clr = 1'b0; run(5);
        // fault counter saturation
        for (int k = 0; k < 300; k++) begin
            ext_err = 1'b1; run(1);
            ext_err = 1'b0; run(13);
            flt_clr = 1'b1; run(1);
            flt_clr = 1'b0; run(2);
        end
        reset = 1'b1; run(1);
        reset = 1'b0;
        // randomized traffic
        for (int k = 0; k < 4000; k++) begin
            if (lamp_hold == 0) begin
                r = $urandom_range(0, 9);
                case (r)
                    0: begin L_A = 3'b110; L_B = 3'b011; end
                    1: begin L_A = 3'b011; L_B = 3'b110; end
                    2: begin L_A = 3'b100; L_B = 3'b011; end
                    3: begin L_A = 3'b011; L_B = 3'b101; end
                    4: begin L_A = 3'b000; L_B = 3'b000; end
                    5: begin L_A = 3'b111; L_B = 3'b111; end
                    6: begin L_A = 3'b110; L_B = 3'b100; end
                    default: begin L_A = 3'($urandom_range(0, 7)); L_B = 3'($urandom_range(0, 7)); end
                endcase
                lamp_hold = $urandom_range(1, 24);
            end
            lamp_hold--;
            if (hold_a == 0) begin btn_a = 1'($urandom_range(0, 1)); hold_a = $urandom_range(1, 8); end
            hold_a--;
            if (hold_b == 0) begin btn_b = 1'($urandom_range(0, 1)); hold_b = $urandom_range(1, 8); end
            hold_b--;
            RA      = ($urandom_range(0, 9) == 0);
            RB      = ($urandom_range(0, 9) == 0);
            ext_err = ($urandom_range(0, 99) == 0);
            flt_clr = ($urandom_range(0, 19) == 0);
            reset   = ($urandom_range(0, 499) == 0);
            tick();
        end
        reset = 1'b0; ext_err = 1'b0; flt_clr = 1'b0;
        run(4);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
